// File: rtl/d7s_pkg.sv
// Shared definitions for the three-digit seven-segment decoder: active-low segment
// codes (bit6=g .. bit0=a), the digit type and the sequencer state encoding.
package d7s_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef logic [3:0] digit_t;

  typedef enum logic [2:0] {
    StIdle,
    StD2,
    StD1,
    StD0,
    StDone
  } state_t;

endpackage

// File: rtl/d7s_seg2dig.sv
// Combinational segment-pattern to decimal-digit lookup.
// Optional feature: D7S_DEC_BLANK_ZERO_EN makes the blank pattern a legal zero.
module d7s_seg2dig
  import d7s_pkg::*;
(
  input  logic [6:0] seg_i,
  output digit_t     digit_o,
  output logic       legal_o
);

  // Illegal patterns report digit 0 so they contribute nothing to the sum.
  always_comb begin
    digit_o = 4'd0;
    legal_o = 1'b1;
    case (seg_i)
      SEG_0: digit_o = 4'd0;
      SEG_1: digit_o = 4'd1;
      SEG_2: digit_o = 4'd2;
      SEG_3: digit_o = 4'd3;
      SEG_4: digit_o = 4'd4;
      SEG_5: digit_o = 4'd5;
      SEG_6: digit_o = 4'd6;
      SEG_7: digit_o = 4'd7;
      SEG_8: digit_o = 4'd8;
      SEG_9: digit_o = 4'd9;
`ifdef D7S_DEC_BLANK_ZERO_EN
      SEG_BLANK: digit_o = 4'd0;
`endif
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/d7s_dec.sv
// Three-digit seven-segment to binary decoder. Captures seg2/seg1/seg0 on start,
// accumulates hundreds, tens, units over three cycles and saturates at 255.
// Optional feature: D7S_DEC_BLANK_ZERO_EN (blank decodes as a legal 0).
module d7s_dec
  import d7s_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] seg0,
  input  logic [6:0] seg1,
  input  logic [6:0] seg2,
  output logic [7:0] value,
  output logic       valid,
  output logic       busy,
  output logic       err,
  output logic       ovf
);

  state_t     state_q, state_d;
  logic [6:0] seg0_q, seg0_d, seg1_q, seg1_d, seg2_q, seg2_d;
  logic [9:0] acc_q, acc_d;
  logic       err_acc_q, err_acc_d;
  logic [7:0] value_q, value_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;
  logic       ovf_q, ovf_d;

  logic [6:0] sel_seg;
  digit_t     dig;
  logic       dig_ok;
  logic [9:0] dig_val;
  logic [9:0] acc_x10;
  logic [9:0] sum;

  // One shared lookup, steered to the digit the current state consumes.
  always_comb begin
    case (state_q)
      StD2:    sel_seg = seg2_q;
      StD1:    sel_seg = seg1_q;
      default: sel_seg = seg0_q;
    endcase
  end

  d7s_seg2dig u_seg2dig (
    .seg_i   (sel_seg),
    .digit_o (dig),
    .legal_o (dig_ok)
  );

  // acc never exceeds 99 before the multiply, so 10 bits hold acc*10+9 without loss.
  always_comb begin
    dig_val = dig_ok ? {6'd0, dig} : 10'd0;
    acc_x10 = (acc_q << 3) + (acc_q << 1);
    sum     = acc_x10 + dig_val;
  end

  // Sequencer next-state and result computation.
  always_comb begin
    state_d   = state_q;
    seg0_d    = seg0_q;
    seg1_d    = seg1_q;
    seg2_d    = seg2_q;
    acc_d     = acc_q;
    err_acc_d = err_acc_q;
    value_d   = value_q;
    err_d     = err_q;
    ovf_d     = ovf_q;
    valid_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          seg0_d  = seg0;
          seg1_d  = seg1;
          seg2_d  = seg2;
          state_d = StD2;
        end
      end
      StD2: begin
        acc_d     = dig_val;
        err_acc_d = ~dig_ok;
        state_d   = StD1;
      end
      StD1: begin
        acc_d     = sum;
        err_acc_d = err_acc_q | ~dig_ok;
        state_d   = StD0;
      end
      StD0: begin
        acc_d   = sum;
        valid_d = 1'b1;
        if (err_acc_q || !dig_ok) begin
          value_d = 8'd0;
          err_d   = 1'b1;
          ovf_d   = 1'b0;
        end else if (sum > 10'd255) begin
          value_d = 8'hFF;
          err_d   = 1'b0;
          ovf_d   = 1'b1;
        end else begin
          value_d = sum[7:0];
          err_d   = 1'b0;
          ovf_d   = 1'b0;
        end
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; reset wins over everything, including start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      seg0_q    <= 7'd0;
      seg1_q    <= 7'd0;
      seg2_q    <= 7'd0;
      acc_q     <= 10'd0;
      err_acc_q <= 1'b0;
      value_q   <= 8'd0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      seg0_q    <= seg0_d;
      seg1_q    <= seg1_d;
      seg2_q    <= seg2_d;
      acc_q     <= acc_d;
      err_acc_q <= err_acc_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
    end
  end

  assign value = value_q;
  assign valid = valid_q;
  assign err   = err_q;
  assign ovf   = ovf_q;
  assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_d7s_dec.sv
// Self-checking bench for d7s_dec: directed vector table, hand-written corner
// sequences and randomized patterns checked against a decimal reference model.
module tb_d7s_dec;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [6:0] seg0, seg1, seg2;
  logic [7:0] value;
  logic       valid, busy, err, ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  d7s_dec dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .seg0  (seg0),
    .seg1  (seg1),
    .seg2  (seg2),
    .value (value),
    .valid (valid),
    .busy  (busy),
    .err   (err),
    .ovf   (ovf)
  );

  // Display codes indexed by the digit they show.
  logic [6:0] codes [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  typedef struct {
    logic [6:0] s2, s1, s0;
    logic [7:0] v;
    logic       e, o;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: digit value of a pattern, or -1 if illegal.
  function automatic int ref_digit(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (codes[i] == s) return i;
`ifdef D7S_DEC_BLANK_ZERO_EN
    if (s == 7'h7F) return 0;
`endif
    return -1;
  endfunction

  function automatic vec_t ref_model(input logic [6:0] s2, s1, s0);
    vec_t r;
    int h, t, u, n;
    r.s2 = s2; r.s1 = s1; r.s0 = s0;
    h = ref_digit(s2); t = ref_digit(s1); u = ref_digit(s0);
    if (h < 0 || t < 0 || u < 0) begin
      r.v = 8'd0; r.e = 1'b1; r.o = 1'b0;
    end else begin
      n = 100 * h + 10 * t + u;
      r.e = 1'b0;
      r.o = (n > 255);
      r.v = (n > 255) ? 8'hFF : n[7:0];
    end
    return r;
  endfunction

  // Runs one decode; with disturb, start stays high into D2 and segs change after capture.
  task automatic do_decode(input vec_t vx, input bit disturb);
    int n, busy_n, extra;
    bit got;
    @(negedge clk);
    seg2 = vx.s2; seg1 = vx.s1; seg0 = vx.s0;
    start = 1'b1;
    @(posedge clk); #1;
    n = 1; busy_n = 0; got = 1'b0;
    if (disturb) begin
      seg2 = ~vx.s2; seg1 = 7'h7F; seg0 = 7'h00;
    end else begin
      start = 1'b0;
    end
    while (n <= 10) begin
      if (busy) busy_n++;
      if (valid) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
      n++;
      if (disturb && n == 2) start = 1'b0;
    end
    start = 1'b0;
    chk("latency", got ? n : 0, 4);
    chk("value", int'(value), int'(vx.v));
    chk("err", int'(err), int'(vx.e));
    chk("ovf", int'(ovf), int'(vx.o));
    chk("busy_cycles", busy_n, 4);
    @(posedge clk); #1;
    chk("valid_width", int'(valid), 0);
    chk("busy_after", int'(busy), 0);
    chk("value_hold", int'(value), int'(vx.v));
    if (disturb) begin
      extra = 0;
      repeat (6) begin
        @(posedge clk); #1;
        if (valid) extra++;
      end
      chk("no_queued_start", extra, 0);
    end
  endtask

  initial begin
    vec_t vecs [$];
    vec_t r;
    int   mask;

    reset = 1'b1; start = 1'b0;
    seg0 = 7'h40; seg1 = 7'h40; seg2 = 7'h40;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_value", int'(value), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_ovf", int'(ovf), 0);
    @(negedge clk); reset = 1'b0;

    // Directed table: s2, s1, s0 -> value, err, ovf
    vecs.push_back('{7'h79, 7'h24, 7'h30, 8'd123, 1'b0, 1'b0});
    vecs.push_back('{7'h24, 7'h12, 7'h12, 8'd255, 1'b0, 1'b0});
    vecs.push_back('{7'h24, 7'h12, 7'h02, 8'hFF, 1'b0, 1'b1});
    vecs.push_back('{7'h10, 7'h10, 7'h10, 8'hFF, 1'b0, 1'b1});
    vecs.push_back('{7'h79, 7'h55, 7'h30, 8'd0, 1'b1, 1'b0});
    vecs.push_back('{7'h40, 7'h40, 7'h40, 8'd0, 1'b0, 1'b0});
    vecs.push_back('{7'h40, 7'h10, 7'h10, 8'd99, 1'b0, 1'b0});
    vecs.push_back('{7'h24, 7'h12, 7'h40, 8'd250, 1'b0, 1'b0});
    vecs.push_back('{7'h10, 7'h10, 7'h55, 8'd0, 1'b1, 1'b0});
`ifdef D7S_DEC_BLANK_ZERO_EN
    vecs.push_back('{7'h7F, 7'h12, 7'h78, 8'd57, 1'b0, 1'b0});
`else
    vecs.push_back('{7'h7F, 7'h12, 7'h78, 8'd0, 1'b1, 1'b0});
`endif
    foreach (vecs[i]) do_decode(vecs[i], 1'b0);

    // Reset in D1 after a result is held: abort, all outputs cleared.
    @(negedge clk);
    seg2 = 7'h10; seg1 = 7'h00; seg0 = 7'h78;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    @(negedge clk); reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    chk("abort_value", int'(value), 0);
    chk("abort_valid", int'(valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_err", int'(err), 0);
    chk("abort_ovf", int'(ovf), 0);
    @(negedge clk); reset = 1'b0; start = 1'b0;
    mask = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (valid) mask++;
    end
    chk("abort_no_valid", mask, 0);
    do_decode('{7'h40, 7'h40, 7'h40, 8'd0, 1'b0, 1'b0}, 1'b0);

    // Start during D2 with inputs changed after capture.
    do_decode('{7'h79, 7'h24, 7'h30, 8'd123, 1'b0, 1'b0}, 1'b1);

    // Start held high: one result every 5 cycles.
    @(negedge clk);
    seg2 = 7'h40; seg1 = 7'h24; seg0 = 7'h19;
    start = 1'b1;
    mask = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (valid) mask |= (1 << i);
    end
    start = 1'b0;
    chk("held_start_pattern", mask, (1 << 4) | (1 << 9));
    chk("held_start_value", int'(value), 24);
    repeat (6) @(posedge clk);

    // Randomized patterns, mostly legal digits with occasional arbitrary codes.
    for (int k = 0; k < 40; k++) begin
      logic [6:0] s [3];
      for (int j = 0; j < 3; j++) begin
        if ($urandom_range(0, 5) == 0) s[j] = 7'($urandom_range(0, 127));
        else s[j] = codes[$urandom_range(0, 9)];
      end
      r = ref_model(s[2], s[1], s[0]);
      do_decode(r, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/d7s_dec.md
D7S_DEC -- requirements
Module: d7s_dec

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The clock and reset ports SHALL be: clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to decode the three segment inputs; sampled only in IDLE.
REQ-005 seg0  input  7  units-digit segment pattern, active-low, bit6=g … bit0=a.
REQ-006 seg1  input  7  tens-digit segment pattern, same encoding.
REQ-007 seg2  input  7  hundreds-digit segment pattern, same encoding.
REQ-008 value  output  8  decoded binary result.
REQ-009 valid  output  1  one-cycle pulse marking value, err and ovf as current.
REQ-010 busy  output  1  high whenever the state is not IDLE.
REQ-011 err  output  1  at least one pattern was not a legal digit.
REQ-012 ovf  output  1  decoded decimal number exceeded 255.

Function
REQ-013 Legal patterns SHALL be these active-low codes: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10; every other code, including blank 7'h7F, SHALL be illegal.
REQ-014 The state machine SHALL use states IDLE, D2, D1, D0 and DONE.
REQ-015 IDLE with start=1 SHALL capture seg2/seg1/seg0 into internal registers and go to D2; IDLE with start=0 SHALL stay in IDLE.
REQ-016 D2 SHALL set acc to the hundreds digit and go to D1.
REQ-017 D1 SHALL set acc to acc*10 plus the tens digit and go to D0.
REQ-018 D0 SHALL compute acc*10 plus the units digit, register value, err, ovf and valid=1, and go to DONE.
REQ-019 DONE SHALL clear valid and return to IDLE.
REQ-020 valid SHALL rise on the 4th rising edge after, and including, the edge that samples start, and SHALL stay high for exactly one cycle.
REQ-021 acc SHALL be 10 bits wide; multiply-by-10 SHALL be implemented as (acc<<3)+(acc<<1) with no truncation below 10 bits.
REQ-022 If the final sum is greater than 255 and all digits are legal, the block SHALL set value=8'hFF, ovf=1 and err=0.
REQ-023 If any captured pattern is illegal, the block SHALL set err=1, value=0 and ovf=0, and the illegal digit SHALL contribute 0 to acc.
REQ-024 value, err and ovf SHALL hold their last result until the next D0 cycle or reset.
REQ-025 start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-026 Changes on seg0..seg2 after the capture edge SHALL NOT affect the result in progress.
REQ-027 The minimum start-to-start spacing SHALL be 5 cycles; start held high continuously SHALL produce one decode every 5 cycles.

Reset
REQ-028 reset=1 on any edge SHALL force state=IDLE, acc=0, value=0, valid=0, err=0 and ovf=0; busy SHALL follow state.
REQ-029 Reset asserted mid-operation SHALL abort the decode with no valid pulse, and reset SHALL take priority over start.

Configuration
REQ-030 With macro D7S_DEC_BLANK_ZERO_EN defined, blank (7'h7F) SHALL be a legal code decoding to 0 in any position, so leading-blank displays decode without err.
REQ-031 Without D7S_DEC_BLANK_ZERO_EN, blank SHALL be illegal per REQ-013.

Structure
REQ-032 A shared package d7s_pkg SHALL hold the segment code constants SEG_0..SEG_9 and SEG_BLANK, the 4-bit digit type, and the state enum.
REQ-033 The segment-to-digit lookup SHALL be a combinational sub-module d7s_seg2dig (7-bit pattern in; 4-bit digit and legal flag out), instantiated once and multiplexed by state, or three times.

Verification
REQ-034 seg2/seg1/seg0=7'h79/7'h24/7'h30 with start pulsed -> valid on the 4th edge, value=123, err=0, ovf=0, busy high for 4 cycles.
REQ-035 Patterns 2,5,5 -> value=255, ovf=0; patterns 2,5,6 -> value=255, ovf=1; patterns 9,9,9 -> value=255, ovf=1.
REQ-036 seg1=7'h55 with the others legal -> err=1, value=0, ovf=0.
REQ-037 seg2=7'h7F, seg1=7'h12, seg0=7'h78 -> value=57, err=0 with the macro defined; err=1, value=0 without it.
REQ-038 start pulsed, reset asserted in D1 -> no valid pulse and all outputs 0 the next cycle; start again with 0,0,0 -> value=0, valid on the 4th edge.
REQ-039 Second start pulsed during D2 and seg inputs changed after capture -> a single valid pulse carrying the originally captured value.
